btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
- Parametrised direct-mapped branch target buffer with per-entry saturating-counter direction predictor.
- Sits beside the IF-stage PC register. It is looked up combinationally with the current PC to choose the next fetch PC.
- It is updated from the EX/MEM stage when a branch resolves.
- Replaces the unused fixed 32x35 BTB array in the current pipeline top. Adds configurable depth, counter width, invalidate-all and statistics counters.

Parameters:
- NUM_ENTRIES, 32, table depth; power of two, >= 2; IDX_W = log2(NUM_ENTRIES).
- PC_W, 32, PC/target width; PC is a word address.
- CNT_W, 2, saturating counter width, >= 1.
- PC_INC, 1, fall-through increment added to the lookup PC.
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- lookup_pc  in  PC_W  current fetch PC.
- pred_hit  out  1  valid entry with tag match for lookup_pc.
- pred_taken  out  1  pred_hit AND counter MSB set.
- pred_next_pc  out  PC_W  stored target if pred_taken, else lookup_pc+PC_INC (mod 2^PC_W).
- upd_valid  in  1  a resolved branch is presented this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_W  actual target (PC + offset).
- upd_pred_taken  in  1  prediction carried down the pipe with the branch.
- upd_pred_target  in  PC_W  predicted next PC carried down the pipe.
- inv_all  in  1  synchronous invalidate of every entry.
- hit_cnt  out  STAT_W  lookups with pred_hit=1.
- upd_cnt  out  STAT_W  accepted updates.
- mispred_cnt  out  STAT_W  mispredicted updates.

Behaviour:
- Entry fields: valid, tag = pc[PC_W-1:IDX_W], target[PC_W], ctr[CNT_W]. Index = pc[IDX_W-1:0].
- Reset (rst=0, async), for every entry:
  - valid=0, target=0, ctr=WEAK_NT (01 for CNT_W=2; value 2^(CNT_W-1)-1 in general).
  - All stat counters = 0.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+PC_INC.
- Lookup: purely combinational from lookup_pc and the table state; 0-cycle latency.
- Update, sampled at the clock edge when upd_valid=1 and inv_all=0:
  - Hit (valid and tag match), taken: ctr = min(ctr+1, max), target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate by overwriting the entry. valid=1, tag, target = upd_target, ctr=WEAK_T (2^(CNT_W-1)).
  - Miss, not taken: table unchanged (no allocation).
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (read-before-write, no bypass). The new state is visible from the next cycle.
- Invalidate:
  - inv_all=1 clears every valid bit at the edge. Targets and counters are unchanged.
  - inv_all wins over a simultaneous update; that update is dropped and not counted.
- Statistics (each saturates at 2^STAT_W-1, never wraps):
  - hit_cnt: +1 per cycle with pred_hit=1.
  - upd_cnt: +1 per accepted update.
  - mispred_cnt: +1 per accepted update where upd_taken != upd_pred_taken, or upd_taken=1 and upd_target != upd_pred_target.
  - inv_all does not clear the statistics; only rst does.
- Arithmetic: all PC arithmetic is unsigned, modulo 2^PC_W. lookup_pc = all-ones wraps to PC_INC-1.

Decomposition:
- Shared package btb_pkg holds:
  - CNT_W-derived constants WEAK_NT, WEAK_T, CTR_MAX.
  - Entry struct/typedef {valid, tag, target, ctr}.
  - Function clog2 for IDX_W.
- One natural sub-module, sat_counter, is parametrised by width, with inc/dec/load ports and saturation.
  - Used for the per-entry update value computation.
  - Also used, at STAT_W, for the three statistics counters.

Test Plan:
- Reset then lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_next_pc=0x41; all stat counters 0.
- Update pc=0x40 taken target=0x10, then next cycle lookup 0x40 -> pred_hit=1, pred_taken=1, pred_next_pc=0x10; upd_cnt=1.
- Same entry, two not-taken updates -> ctr 10->01->00, lookup gives pred_taken=0, pred_next_pc=0x41. Four taken updates saturate ctr at 11; a fifth leaves it at 11.
- Alias with NUM_ENTRIES=32: entry for 0x40, then taken update pc=0x60 (same index 0) target=0x80 -> lookup 0x40 misses, lookup 0x60 hits with target 0x80. A not-taken update at pc=0x20 leaves the table unchanged.
- Same-cycle update pc=0x40 and lookup 0x40 on an empty table -> pred_hit=0 that cycle, 1 the next. inv_all together with an update -> entry invalid afterwards, upd_cnt unchanged.
- Update with upd_taken=1, upd_pred_taken=1, upd_pred_target=0x11, upd_target=0x10 -> mispred_cnt +1. With STAT_W=2, after 5 hits hit_cnt=3. Assert rst mid-sequence -> all entries invalid and counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared constants and helpers for the branch target buffer and its saturating counters.
package btb_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Counter encodings derived from the counter width w.
    function automatic logic [63:0] weak_nt(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] weak_t(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] ctr_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// Combinational next-value of a W-bit saturating counter with load, increment and decrement.
module sat_counter
    import btb_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] nxt_c
);

    localparam logic [W-1:0] MAX = W'(ctr_max(W));

    // Load has priority; simultaneous inc and dec cancel.
    always_comb begin
        nxt_c = cur;
        if (load) begin
            nxt_c = load_val;
        end else if (inc && !dec) begin
            nxt_c = (cur == MAX) ? cur : cur + W'(1);
        end else if (dec && !inc) begin
            nxt_c = (cur == '0) ? cur : cur - W'(1);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters and
// saturating lookup/update/mispredict statistics.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned PC_INC      = 1,
    parameter int unsigned STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_next_pc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_target,
    input  logic              inv_all,
    output logic [STAT_W-1:0] hit_cnt,
    output logic [STAT_W-1:0] upd_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int unsigned IDX_W = clog2(NUM_ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W;
    localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(weak_nt(CNT_W));
    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(weak_t(CNT_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CNT_W-1:0] ctr;
    } entry_t;

    entry_t tbl_q [NUM_ENTRIES];

    // Lookup path: read-before-write, no bypass of a same-cycle update.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    entry_t           lk_ent;

    always_comb begin
        lk_idx       = lookup_pc[IDX_W-1:0];
        lk_tag       = lookup_pc[PC_W-1:IDX_W];
        lk_ent       = tbl_q[lk_idx];
        pred_hit     = lk_ent.valid && (lk_ent.tag == lk_tag);
        pred_taken   = pred_hit && lk_ent.ctr[CNT_W-1];
        pred_next_pc = pred_taken ? lk_ent.target : lookup_pc + PC_W'(PC_INC);
    end

    // Update path decode.
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    entry_t           up_ent;
    logic             up_hit;
    logic             upd_accept_c;
    logic             mispred_c;
    logic [CNT_W-1:0] ctr_nxt_c;

    always_comb begin
        up_idx       = upd_pc[IDX_W-1:0];
        up_tag       = upd_pc[PC_W-1:IDX_W];
        up_ent       = tbl_q[up_idx];
        up_hit       = up_ent.valid && (up_ent.tag == up_tag);
        upd_accept_c = upd_valid && !inv_all;
        mispred_c    = (upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target));
    end

    // On a miss the counter loads WEAK_T; only written back when allocating.
    sat_counter #(.W(CNT_W)) u_entry_ctr (
        .cur      (up_ent.ctr),
        .inc      (upd_taken),
        .dec      (!upd_taken),
        .load     (!up_hit),
        .load_val (WEAK_T),
        .nxt_c    (ctr_nxt_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
            end
        end else if (inv_all) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                tbl_q[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                tbl_q[up_idx].ctr <= ctr_nxt_c;
                if (upd_taken) tbl_q[up_idx].target <= upd_target;
            end else if (upd_taken) begin
                tbl_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: ctr_nxt_c};
            end
        end
    end

    // Statistics counters, saturating; cleared only by reset.
    logic [STAT_W-1:0] hit_nxt_c;
    logic [STAT_W-1:0] upd_nxt_c;
    logic [STAT_W-1:0] mis_nxt_c;

    sat_counter #(.W(STAT_W)) u_hit_stat (
        .cur      (hit_cnt),
        .inc      (pred_hit),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .nxt_c    (hit_nxt_c)
    );

    sat_counter #(.W(STAT_W)) u_upd_stat (
        .cur      (upd_cnt),
        .inc      (upd_accept_c),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .nxt_c    (upd_nxt_c)
    );

    sat_counter #(.W(STAT_W)) u_mis_stat (
        .cur      (mispred_cnt),
        .inc      (upd_accept_c && mispred_c),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .nxt_c    (mis_nxt_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt     <= '0;
            upd_cnt     <= '0;
            mispred_cnt <= '0;
        end else begin
            hit_cnt     <= hit_nxt_c;
            upd_cnt     <= upd_nxt_c;
            mispred_cnt <= mis_nxt_c;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed table-driven bench for btb_predictor; a second instance with 2-bit stats checks saturation.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        inv_all;

    logic        pred_hit, pred_taken;
    logic [31:0] pred_next_pc;
    logic [15:0] hit_cnt, upd_cnt, mispred_cnt;

    logic        s_pred_hit, s_pred_taken;
    logic [31:0] s_pred_next_pc;
    logic [1:0]  s_hit_cnt, s_upd_cnt, s_mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    btb_predictor #(.NUM_ENTRIES(32), .PC_W(32), .CNT_W(2), .PC_INC(1), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .inv_all(inv_all),
        .hit_cnt(hit_cnt), .upd_cnt(upd_cnt), .mispred_cnt(mispred_cnt)
    );

    btb_predictor #(.NUM_ENTRIES(32), .PC_W(32), .CNT_W(2), .PC_INC(1), .STAT_W(2)) dut_s (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(s_pred_hit), .pred_taken(s_pred_taken), .pred_next_pc(s_pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .inv_all(inv_all),
        .hit_cnt(s_hit_cnt), .upd_cnt(s_upd_cnt), .mispred_cnt(s_mispred_cnt)
    );

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        utk;
        logic [31:0] utgt;
        logic        uptk;
        logic [31:0] uptgt;
        logic        inv;
        logic [31:0] lpc;
        logic        ehit;
        logic        etk;
        logic [31:0] enext;
        int          ehc;
        int          euc;
        int          emc;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic utk,
                                input logic [31:0] utgt, input logic uptk, input logic [31:0] uptgt,
                                input logic inv, input logic [31:0] lpc, input logic ehit,
                                input logic etk, input logic [31:0] enext,
                                input int ehc, input int euc, input int emc);
        vec_t v;
        v.uv = uv; v.upc = upc; v.utk = utk; v.utgt = utgt; v.uptk = uptk; v.uptgt = uptgt;
        v.inv = inv; v.lpc = lpc; v.ehit = ehit; v.etk = etk; v.enext = enext;
        v.ehc = ehc; v.euc = euc; v.emc = emc;
        return v;
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        // Each row: update fields, lookup_pc, expected lookup result (pre-update), stats before this edge.
        //             uv  upc      tk  tgt      ptk ptgt     inv lookup        hit tk  next          hc  uc  mc
        vecs[0]  = mk(0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'h40,       0, 0, 32'h41,        0,  0,  0);
        vecs[1]  = mk(1, 32'h40, 1, 32'h10, 0, 32'h41, 0, 32'h40,       0, 0, 32'h41,        0,  0,  0);
        vecs[2]  = mk(0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'h40,       1, 1, 32'h10,        0,  1,  1);
        vecs[3]  = mk(1, 32'h40, 0, 32'h00, 1, 32'h10, 0, 32'h40,       1, 1, 32'h10,        1,  1,  1);
        vecs[4]  = mk(1, 32'h40, 0, 32'h00, 0, 32'h41, 0, 32'h40,       1, 0, 32'h41,        2,  2,  2);
        vecs[5]  = mk(0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'h40,       1, 0, 32'h41,        3,  3,  2);
        vecs[6]  = mk(1, 32'h40, 1, 32'h10, 0, 32'h41, 0, 32'h41,       0, 0, 32'h42,        4,  3,  2);
        vecs[7]  = mk(1, 32'h40, 1, 32'h10, 0, 32'h41, 0, 32'h40,       1, 0, 32'h41,        4,  4,  3);
        vecs[8]  = mk(1, 32'h40, 1, 32'h10, 1, 32'h10, 0, 32'h40,       1, 1, 32'h10,        5,  5,  4);
        vecs[9]  = mk(1, 32'h40, 1, 32'h10, 1, 32'h10, 0, 32'h40,       1, 1, 32'h10,        6,  6,  4);
        vecs[10] = mk(1, 32'h40, 1, 32'h10, 1, 32'h10, 0, 32'h40,       1, 1, 32'h10,        7,  7,  4);
        vecs[11] = mk(1, 32'h40, 0, 32'h00, 1, 32'h10, 0, 32'h40,       1, 1, 32'h10,        8,  8,  4);
        vecs[12] = mk(0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'h40,       1, 1, 32'h10,        9,  9,  5);
        vecs[13] = mk(1, 32'h60, 1, 32'h80, 0, 32'h61, 0, 32'h60,       0, 0, 32'h61,       10,  9,  5);
        vecs[14] = mk(1, 32'h20, 0, 32'h00, 0, 32'h21, 0, 32'h40,       0, 0, 32'h41,       10, 10,  6);
        vecs[15] = mk(0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'h60,       1, 1, 32'h80,       10, 11,  6);
        vecs[16] = mk(0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'h20,       0, 0, 32'h21,       11, 11,  6);
        vecs[17] = mk(1, 32'h41, 1, 32'h33, 0, 32'h42, 1, 32'h60,       1, 1, 32'h80,       11, 11,  6);
        vecs[18] = mk(0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'h60,       0, 0, 32'h61,       12, 11,  6);
        vecs[19] = mk(0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'h41,       0, 0, 32'h42,       12, 11,  6);
        vecs[20] = mk(0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        12, 11,  6);
        vecs[21] = mk(1, 32'h05, 1, 32'h10, 1, 32'h11, 0, 32'h05,       0, 0, 32'h06,       12, 11,  6);
        vecs[22] = mk(0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'h05,       1, 1, 32'h10,       12, 12,  7);
        vecs[23] = mk(0, 32'h00, 0, 32'h00, 0, 32'h00, 0, 32'h00,       0, 0, 32'h01,       13, 12,  7);

        rst = 1'b0;
        lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0; inv_all = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            upd_valid       = vecs[i].uv;
            upd_pc          = vecs[i].upc;
            upd_taken       = vecs[i].utk;
            upd_target      = vecs[i].utgt;
            upd_pred_taken  = vecs[i].uptk;
            upd_pred_target = vecs[i].uptgt;
            inv_all         = vecs[i].inv;
            lookup_pc       = vecs[i].lpc;
            #1;
            check($sformatf("v%0d pred_hit", i),     32'(pred_hit),     32'(vecs[i].ehit));
            check($sformatf("v%0d pred_taken", i),   32'(pred_taken),   32'(vecs[i].etk));
            check($sformatf("v%0d pred_next_pc", i), pred_next_pc,      vecs[i].enext);
            check($sformatf("v%0d hit_cnt", i),      32'(hit_cnt),      32'(vecs[i].ehc));
            check($sformatf("v%0d upd_cnt", i),      32'(upd_cnt),      32'(vecs[i].euc));
            check($sformatf("v%0d mispred_cnt", i),  32'(mispred_cnt),  32'(vecs[i].emc));
            check($sformatf("v%0d s_pred_next_pc", i), s_pred_next_pc,  vecs[i].enext);
            check($sformatf("v%0d s_hit_cnt", i),    32'(s_hit_cnt),    32'(sat3(vecs[i].ehc)));
            check($sformatf("v%0d s_upd_cnt", i),    32'(s_upd_cnt),    32'(sat3(vecs[i].euc)));
            check($sformatf("v%0d s_mispred_cnt", i), 32'(s_mispred_cnt), 32'(sat3(vecs[i].emc)));
        end

        // Asynchronous reset mid-cycle: state clears without a clock edge.
        @(negedge clk);
        upd_valid = 1'b0; inv_all = 1'b0; lookup_pc = 32'h05;
        #1;
        check("pre_rst pred_hit", 32'(pred_hit), 32'd1);
        check("pre_rst hit_cnt", 32'(hit_cnt), 32'd13);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst pred_hit",     32'(pred_hit),     32'd0);
        check("async_rst pred_taken",   32'(pred_taken),   32'd0);
        check("async_rst pred_next_pc", pred_next_pc,      32'h06);
        check("async_rst hit_cnt",      32'(hit_cnt),      32'd0);
        check("async_rst upd_cnt",      32'(upd_cnt),      32'd0);
        check("async_rst mispred_cnt",  32'(mispred_cnt),  32'd0);
        check("async_rst s_hit_cnt",    32'(s_hit_cnt),    32'd0);

        @(negedge clk);
        rst = 1'b1;
        lookup_pc = 32'h40;
        #1;
        check("post_rst pred_hit 0x40", 32'(pred_hit), 32'd0);
        @(negedge clk);
        check("post_rst hit_cnt", 32'(hit_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
